// File: rtl/dmem_mmio_if.sv
// Core-side data-memory bus plus the console byte stream, bundled for the
// dmem_mmio_ctrl block. The master is the core/testbench side and the slave is the controller.
interface dmem_mmio_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   mem_addr_in;
    logic [DATA_WIDTH-1:0]   mem_data_in;
    logic                    mem_we_in;
    logic [DATA_WIDTH/8-1:0] mem_mask_in;
    logic [DATA_WIDTH-1:0]   mem_data_out;

    // Console stream: a byte moves on a rising clk edge where con_valid and
    // con_ready are both high; con_data is stable while con_valid is high.
    logic [7:0]              con_data;
    logic                    con_valid;
    logic                    con_ready;

    modport master (
        output mem_addr_in, mem_data_in, mem_we_in, mem_mask_in,
        input  mem_data_out,
        input  con_data, con_valid,
        output con_ready
    );

    modport slave (
        input  mem_addr_in, mem_data_in, mem_we_in, mem_mask_in,
        output mem_data_out,
        output con_data, con_valid,
        input  con_ready
    );
endinterface

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory controller: byte-maskable RAM with a same-cycle read path, plus an MMIO
// window holding mcycle, mtimecmp/timer_irq, the console TX FIFO and a sticky halt register.
module dmem_mmio_ctrl #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          DMEM_SZ_IN_KB  = 1,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          CON_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    dmem_mmio_if.slave            bus,
    output logic                  timer_irq,
    output logic                  halt,
    output logic [DATA_WIDTH-1:0] halt_code
);
    localparam int WORDS = DMEM_SZ_IN_KB * 256;
    localparam int AW    = $clog2(WORDS);
    localparam int PW    = $clog2(CON_FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = CON_FIFO_DEPTH[PW:0];

    localparam logic [2:0] OFF_MCYCLE_LO   = 3'd0;
    localparam logic [2:0] OFF_MCYCLE_HI   = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CON_TX      = 3'd4;
    localparam logic [2:0] OFF_CON_STATUS  = 3'd5;
    localparam logic [2:0] OFF_HALT        = 3'd6;

    logic [DATA_WIDTH-1:0] ram [WORDS];
    logic [7:0]            fifo_mem [CON_FIFO_DEPTH];

    logic [31:0]           offset;
    logic                  is_mmio;
    logic [2:0]            reg_sel;
    logic [AW-1:0]         word_idx;
    logic                  mmio_wr;
    logic                  con_push;
    logic                  push_ok;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [63:0]           mcycle;
    logic [63:0]           mtimecmp;
    logic                  overflow;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    // Unsigned subtract folds both window bounds into one compare, with no overflow at the top.
    assign offset   = bus.mem_addr_in - MMIO_BASE;
    assign is_mmio  = offset < 32'h20;
    assign reg_sel  = offset[4:2];
    assign word_idx = bus.mem_addr_in[AW+1:2];

    assign mmio_wr    = bus.mem_we_in & is_mmio;
    assign con_push   = mmio_wr && (reg_sel == OFF_CON_TX);
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign push_ok    = con_push & ~fifo_full;
    assign pop        = ~fifo_empty & bus.con_ready;

    assign bus.con_valid = ~fifo_empty;
    assign bus.con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        mmio_rdata = '0;
        case (reg_sel)
            OFF_MCYCLE_LO:   mmio_rdata = mcycle[31:0];
            OFF_MCYCLE_HI:   mmio_rdata = mcycle[63:32];
            OFF_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
            OFF_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
            OFF_CON_STATUS:  mmio_rdata = {16'h0, 8'(count), 5'h0, overflow, fifo_empty, fifo_full};
            default:         mmio_rdata = '0;
        endcase
    end

    assign bus.mem_data_out = is_mmio ? mmio_rdata : ram[word_idx];

    // RAM and FIFO storage carry no reset; only the FIFO pointers decide what is live.
    always_ff @(posedge clk) begin
        if (bus.mem_we_in && !is_mmio) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (bus.mem_mask_in[i]) begin
                    ram[word_idx][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
                end
            end
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.mem_data_in[7:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mcycle    <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            mcycle    <= mcycle + 64'd1;
            timer_irq <= (mcycle >= mtimecmp);
            if (con_push && fifo_full) overflow <= 1'b1;
            if (mmio_wr) begin
                case (reg_sel)
                    OFF_MTIMECMP_LO: mtimecmp[31:0]  <= bus.mem_data_in;
                    OFF_MTIMECMP_HI: mtimecmp[63:32] <= bus.mem_data_in;
                    OFF_CON_STATUS:  overflow <= 1'b0;
                    OFF_HALT: begin
                        if (!halt) begin
                            halt      <= 1'b1;
                            halt_code <= bus.mem_data_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/dmem_mmio_ctrl.md
Name: dmem_mmio_ctrl

Overview:
Shared data-memory controller sitting directly downstream of the core's data-memory ports. It consumes the core's address, write data, write enable and byte mask, and returns read data in the same cycle. It serves a byte-maskable data RAM plus a small MMIO window. The window holds a 64-bit cycle counter, a timer compare with interrupt, a buffered console-TX FIFO with a valid/ready output, and a halt register for test termination.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
DMEM_SZ_IN_KB, 1, RAM size in KiB (word count = DMEM_SZ_IN_KB*256)
MMIO_BASE, 32'h8000_0000, byte base address of MMIO window (0x20 bytes)
CON_FIFO_DEPTH, 8, console FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
mem_addr_in  in  DATA_WIDTH  byte address from core
mem_data_in  in  DATA_WIDTH  write data from core
mem_we_in  in  1  write enable from core
mem_mask_in  in  DATA_WIDTH/8  byte write mask from core
mem_data_out  out  DATA_WIDTH  read data to core (combinational)
con_data  out  8  console byte at FIFO head
con_valid  out  1  FIFO non-empty
con_ready  in  1  sink accepts con_data
timer_irq  out  1  mcycle >= mtimecmp (registered)
halt  out  1  sticky halt flag
halt_code  out  DATA_WIDTH  value written to HALT

Behaviour:
- Clock and reset: single clock `clk`; reset `arst_n` is asynchronous, active-low.
- Address decode:
  - MMIO when MMIO_BASE <= addr < MMIO_BASE+0x20.
  - Otherwise RAM, word index = addr[log2(words)+1:2]. Upper bits ignored, so RAM wraps. addr[1:0] is ignored.
- Reads:
  - Combinational, same-cycle.
  - Always side-effect free, because the core presents an address every cycle.
  - Unmapped MMIO offsets read 0.
- RAM write: on posedge when mem_we_in=1, each byte i is written where mem_mask_in[i]=1. A mask of 0 writes nothing. RAM contents are not cleared by reset.
- MMIO writes use the full word and ignore the mask. Offsets:
  - 0x00 MCYCLE_LO: RO.
  - 0x04 MCYCLE_HI: RO. mcycle is 64-bit, increments every cycle, wraps to 0, reset 0. Writes are ignored.
  - 0x08 MTIMECMP_LO and 0x0C MTIMECMP_HI: RW. Reset value is all ones.
  - 0x10 CON_TX: WO. Pushes data[7:0].
  - 0x14 CON_STATUS:
    - Read fields: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count.
    - Any write clears overflow.
  - 0x18 HALT: WO. The first write sets halt=1 and halt_code=data. Later writes are ignored until reset.
- timer_irq: flop loaded each cycle with (mcycle >= mtimecmp), comparing current register values. If mcycle==mtimecmp in cycle N, irq is high from N+1. Reset 0.
- Console FIFO:
  - Circular buffer with rd/wr pointers and count 0..CON_FIFO_DEPTH.
  - con_valid = (count!=0); con_data = head entry (0 when empty).
  - Pop on posedge when con_valid & con_ready.
  - Push on CON_TX write when count<CON_FIFO_DEPTH, judged on pre-edge count.
  - Push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo depth.
- Reset values: count=0, pointers=0, overflow=0, mcycle=0, timer_irq=0, halt=0, halt_code=0, con_valid=0, con_data=0.
- Reset mid-operation: FIFO contents are discarded and a pending con_valid drops asynchronously.
- Halt does not block RAM or MMIO accesses.

Test Plan:
- RAM byte mask: write 0xAABBCCDD to 0x10 with mask 4'b1111, then write 0x11223344 with mask 4'b0101 -> read 0x10 returns 0xAA22CC44. A read of 0x10+DMEM bytes returns the same (wrap).
- Cycle counter: read MCYCLE_LO 5 cycles apart -> difference 5. Force LO to 0xFFFF_FFFF -> the next cycle HI increments by 1.
- Timer: write MTIMECMP_HI=0, then MTIMECMP_LO=mcycle+10 -> timer_irq rises exactly one cycle after mcycle equals compare. Writing MTIMECMP_HI=0xFFFF_FFFF deasserts it next cycle.
- Console FIFO: con_ready=0, push 9 bytes 0x41..0x49 -> status count=8, full=1, overflow=1. Raise con_ready -> con_data sequence 0x41..0x48, then con_valid=0. A CON_STATUS write clears overflow.
- Simultaneous push and pop at count=3 -> count stays 3 and order is preserved. Push at full with pop in the same cycle -> byte dropped, overflow=1, count=7.
- Halt and reset: write HALT=0x1 then HALT=0x5 -> halt=1, halt_code=1. Assert arst_n low mid-FIFO-drain -> all outputs reach reset values immediately, and RAM still holds prior data after release.
